// File: rtl/regfile_pkg.sv
// Shared types and byte-merge helper for the multi-port register file.
// Widths up to MERGE_W bits are supported by the merge helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int MERGE_W = 256;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] strb
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MERGE_W/8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_ctl.sv
// Clear-walk controller: zeroes every entry after reset, then holds READY.
// The extra counter bit gives one settle cycle after the last entry is cleared.
import regfile_pkg::*;

module regfile_clr_ctl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q[ADDR_W]) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: ;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign clr_we  = (state_q == CLEAR) && !cnt_q[ADDR_W];
  assign clr_idx = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte strobes and post-reset clear walk.
// Define REGFILE_BYPASS_EN to forward an accepted write to same-cycle reads.
import regfile_pkg::*;

module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic                    wren,
  output logic                    busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_acc;
  logic [DATA_W-1:0] merged;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;

  regfile_clr_ctl #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_acc = wren && !busy &&
                  !((ZERO_R0 != 0) && (waddr == '0));

  assign merged = DATA_W'(byte_merge(MERGE_W'(mem_q[waddr]),
                                     MERGE_W'(wdata),
                                     (MERGE_W/8)'(wstrb)));

  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_idx] = '0;
    end else if (wr_acc) begin
      mem_d[waddr] = merged;
    end
  end

  // No parallel reset: the clear walk is the only path that zeroes entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rdata = '0;
    ra    = '0;
    rd    = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && (ra == waddr)) rd = merged;
`endif
      if (busy || ((ZERO_R0 != 0) && (ra == '0))) rd = '0;
      rdata[i*DATA_W +: DATA_W] = rd;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default and 4-port/no-zero builds).
module tb_regfile_mp;

  logic         clk;
  logic         rst_n;
  logic [9:0]   raddr0;
  logic [63:0]  rdata0;
  logic [19:0]  raddr1;
  logic [127:0] rdata1;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wren;
  logic         busy0;
  logic         busy1;

  int vecs;
  int errs;

  regfile_mp u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr0),
    .rdata (rdata0),
    .waddr (waddr),
    .wdata (wdata),
    .wstrb (wstrb),
    .wren  (wren),
    .busy  (busy0)
  );

  regfile_mp #(
    .NREAD   (4),
    .ZERO_R0 (0)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr1),
    .rdata (rdata1),
    .waddr (waddr),
    .wdata (wdata),
    .wstrb (wstrb),
    .wren  (wren),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    waddr = a;
    wdata = d;
    wstrb = s;
    wren  = 1'b1;
    tick();
    wren  = 1'b0;
  endtask

  int   n;
  logic ok;
  logic [31:0] bp_exp;

  initial begin
    vecs   = 0;
    errs   = 0;
    rst_n  = 1'b0;
    raddr0 = '0;
    raddr1 = '0;
    waddr  = '0;
    wdata  = '0;
    wstrb  = '0;
    wren   = 1'b0;

    // reset held 3 cycles, then clear walk
    repeat (3) tick();
    check("busy_in_reset", 128'(busy0), 128'd1);
    raddr0 = {5'd5, 5'd9};
    raddr1 = {5'd1, 5'd2, 5'd3, 5'd4};
    rst_n  = 1'b1;
    n  = 0;
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!busy0) break;
      n++;
      if (rdata0 !== '0 || rdata1 !== '0) ok = 1'b0;
    end
    check("busy_len", 128'(n), 128'd32);
    check("rdata_zero_busy", 128'(ok), 128'd1);

    ok = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr0 = {5'(a), 5'(a)};
      raddr1 = {4{5'(a)}};
      #1;
      if (rdata0 !== '0) ok = 1'b0;
    end
    check("all_zero_u0", 128'(ok), 128'd1);
    ok = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = {4{5'(a)}};
      #1;
      if (rdata1 !== '0) ok = 1'b0;
    end
    check("all_zero_u1", 128'(ok), 128'd1);

    // byte strobes
    wr(5'd5, 32'hAABBCCDD, 4'hF);
    wr(5'd5, 32'h11223344, 4'h5);
    raddr0 = {5'd0, 5'd5};
    #1;
    check("strobe", 128'(rdata0[31:0]), 128'h AA22CC44);
    wr(5'd5, 32'h99999999, 4'h0);
    #1;
    check("strb_zero", 128'(rdata0[31:0]), 128'h AA22CC44);

    // zero register
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    raddr0 = {5'd0, 5'd0};
    raddr1 = {4{5'd0}};
    #1;
    check("r0_zero", 128'(rdata0), 128'd0);
    check("r0_nozero", 128'(rdata1[31:0]), 128'h FFFFFFFF);

    // same-cycle read during write
`ifdef REGFILE_BYPASS_EN
    bp_exp = 32'h00005678;
`else
    bp_exp = 32'h0;
`endif
    raddr0 = {5'd7, 5'd0};
    waddr  = 5'd7;
    wdata  = 32'h12345678;
    wstrb  = 4'h3;
    wren   = 1'b1;
    #1;
    check("bypass_same", 128'(rdata0[63:32]), 128'(bp_exp));
    tick();
    wren = 1'b0;
    #1;
    check("bypass_next", 128'(rdata0[63:32]), 128'h 00005678);

    // all ports same address
    wr(5'd9, 32'hDEADBEEF, 4'hF);
    raddr1 = {4{5'd9}};
    raddr0 = {5'd9, 5'd9};
    #1;
    check("multi_u1", rdata1, {4{32'hDEADBEEF}});
    check("multi_u0", 128'(rdata0), 128'({2{32'hDEADBEEF}}));

    // READY holds
    repeat (40) tick();
    check("ready_hold", 128'({busy0, busy1}), 128'd0);

    // reset mid-clear, writes during busy dropped
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    waddr = 5'd3;
    wdata = 32'h55555555;
    wstrb = 4'hF;
    wren  = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (n == 5) wren = 1'b0;
      if (!busy0) break;
      n++;
    end
    wren = 1'b0;
    check("busy_len_restart", 128'(n), 128'd32);
    raddr0 = {5'd5, 5'd3};
    raddr1 = {4{5'd3}};
    #1;
    check("addr3_dropped", 128'(rdata0[31:0]), 128'd0);
    check("addr5_cleared", 128'(rdata0[63:32]), 128'd0);
    check("addr3_u1", rdata1, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_R0, default 1, 1 = entry 0 hardwired to zero.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 raddr  in  NREAD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 rdata  out  NREAD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W].
REQ-009 waddr  in  ADDR_W  write address.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 wstrb  in  DATA_W/8  byte write enables, bit b covers wdata[8b+7:8b].
REQ-012 wren  in  1  write request, sampled on rising clk.
REQ-013 busy  out  1  high while the clear sequence runs; writes are not accepted.

Function
REQ-014 Reads SHALL be combinational (zero-cycle latency) on every port independently; identical addresses on several ports are legal.
REQ-015 A write SHALL update only the bytes whose wstrb bit is 1, at the rising edge where wren=1 and busy=0.
REQ-016 wren=1 with wstrb=0 SHALL leave the array unchanged.
REQ-017 When ZERO_R0=1, writes to address 0 SHALL be dropped and all ports reading address 0 SHALL return 0.
REQ-018 Control FSM SHALL have two states, CLEAR and READY; busy=1 exactly when state is CLEAR.
REQ-019 In CLEAR, a clear index SHALL start at 0 and write all-zero to entry[index] each cycle, incrementing by 1.
REQ-020 CLEAR SHALL transition to READY on the cycle after index DEPTH-1 is cleared; index wrap SHALL NOT re-enter CLEAR.
REQ-021 While busy=1, wren SHALL be ignored (write dropped, not queued) and every rdata port SHALL return 0.
REQ-022 READY SHALL be held until rst_n is sampled low.

Reset
REQ-023 rst_n sampled low SHALL force state CLEAR, clear index 0, busy=1 on the following cycle and for as long as rst_n stays low.
REQ-024 While rst_n is low, the clear index SHALL hold at 0; the clear walk begins on the first rising edge with rst_n=1.
REQ-025 Reset asserted mid-clear SHALL restart the walk from index 0; busy SHALL deassert exactly DEPTH cycles after the first edge with rst_n high.
REQ-026 Array contents SHALL NOT be reset in parallel; only the FSM walk clears them.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read port whose address equals waddr during an accepted write SHALL return the old word with strobed bytes replaced by wdata in the same cycle (ZERO_R0 still overrides address 0).
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return the pre-write contents until the next clock edge.

Structure
REQ-029 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, READY) and the byte-merge function shared by the write path and the bypass path.
REQ-030 Sub-module regfile_clr_ctl SHALL implement the FSM, clear index and busy; the array, write path and read ports stay in regfile_mp.

Verification
REQ-031 Reset: rst_n low 3 cycles, then high -> busy=1 for exactly 32 cycles, all rdata=0 meanwhile; afterwards read every address -> 0.
REQ-032 Byte strobe: write addr 5 = 0xAABBCCDD wstrb=0xF, then 0x11223344 wstrb=0x5 -> addr 5 reads 0xAA22CC44.
REQ-033 Zero register: write addr 0 = 0xFFFFFFFF -> both ports reading addr 0 return 0; repeat with ZERO_R0=0 -> returns 0xFFFFFFFF.
REQ-034 Bypass: addr 7 holds 0x0; write 0x12345678 wstrb=0x3 while port 1 reads addr 7 -> same cycle rdata1=0x00005678 with REGFILE_BYPASS_EN, 0x0 without; next cycle 0x00005678 in both builds.
REQ-035 Reset mid-clear: release reset, assert rst_n low at clear cycle 10 for 1 cycle, release -> busy stays high another 32 cycles; write with wren=1 during busy to addr 3 -> addr 3 reads 0 after busy falls.
REQ-036 Multi-port: NREAD=4, all ports read addr 9 holding 0xDEADBEEF -> all four rdata = 0xDEADBEEF.
